// File: rtl/key_debounce_if.sv
// Key debounce interface: raw active-low key in, debounced level and event pulses out.
interface key_debounce_if;
    logic       key_n_i;
    logic       key_level_o;
    logic       press_o;
    logic       release_o;
    logic       long_press_o;
    logic [7:0] press_count_o;

    // Board / consumer side: drives the raw key and observes the debounced results.
    modport master (
        output key_n_i,
        input  key_level_o,
        input  press_o,
        input  release_o,
        input  long_press_o,
        input  press_count_o
    );

    // Debouncer side: samples the raw key and produces the debounced results.
    modport slave (
        input  key_n_i,
        output key_level_o,
        output press_o,
        output release_o,
        output long_press_o,
        output press_count_o
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button debouncer.
// The asynchronous active-low key is synchronized, then qualified by a four-state machine.
// A level change is accepted only after a run of identical samples.
// The debouncer produces a debounced level, press/release pulses, a long-press pulse and a wrapping press counter.
module key_debounce #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int LONG_CYCLES   = 50000000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    key_debounce_if.slave bus
);

    localparam int STW = $clog2(STABLE_CYCLES);
    localparam int HW  = $clog2(LONG_CYCLES + 1);

    localparam logic [STW-1:0] STAB_LAST = STW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0]  HOLD_PRE  = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic           sync1_q, sync2_q;
    state_t         state_q, state_d;
    logic [STW-1:0] stab_q, stab_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           long_q, long_d;
    logic [7:0]     count_q, count_d;
    logic           sample;

    assign sample = sync2_q;

    // Two-flop synchronizer; resets to the released level (1) so a held key is re-qualified after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.key_n_i;
            sync2_q <= sync1_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= RELEASED;
            stab_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= '0;
            long_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            long_q    <= long_d;
            count_q   <= count_d;
        end
    end

    // Debounce state machine: a stability counter qualifies each candidate level change.
    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!sample) begin
                    state_d = PRESS_WAIT;
                    stab_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (sample) begin
                    state_d = RELEASED;
                    stab_d  = '0;
                end else if (stab_q == STAB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end else begin
                    stab_d = stab_q + STW'(1);
                end
            end
            PRESSED: begin
                if (sample) begin
                    state_d = RELEASE_WAIT;
                    stab_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!sample) begin
                    state_d = PRESSED;
                end else if (stab_q == STAB_LAST) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                end else begin
                    stab_d = stab_q + STW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                stab_d  = '0;
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // Hold timer and press counter.
    // The hold timer restarts only on a fresh press and saturates, so a release bounce cannot re-fire long_press.
    always_comb begin
        hold_d  = hold_q;
        long_d  = 1'b0;
        count_d = count_q;
        if (press_d) begin
            hold_d  = '0;
            count_d = count_q + 8'd1;
        end else if (level_q && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HW'(1);
            long_d = (hold_q == HOLD_PRE);
        end
    end

    assign bus.key_level_o   = level_q;
    assign bus.press_o       = press_q;
    assign bus.release_o     = release_q;
    assign bus.long_press_o  = long_q;
    assign bus.press_count_o = count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce.
// Directed and random key waveforms are checked every cycle against a run-length reference model.
module tb_key_debounce;

    localparam int S = 4;
    localparam int L = 16;

    logic sys_clk;
    logic sys_rst;
    key_debounce_if bus ();

    key_debounce #(
        .STABLE_CYCLES(S),
        .LONG_CYCLES  (L)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    int checks;
    int errors;
    int pressSeen, releaseSeen, longSeen;

    // Reference model state.
    // A level flips once S+1 consecutive samples disagree with it:
    // the first sample leaves the idle state, then S samples are counted.
    logic       mSync1, mSync2;
    logic       mLevel;
    int         mRun;
    int         mHold;
    bit         mFlagged;
    logic [7:0] mCount;
    logic       expPress, expRelease, expLong;

    // Free-running 50 MHz clock.
    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mSync1     = 1'b1;
        mSync2     = 1'b1;
        mLevel     = 1'b0;
        mRun       = 0;
        mHold      = 0;
        mFlagged   = 1'b0;
        mCount     = 8'd0;
        expPress   = 1'b0;
        expRelease = 1'b0;
        expLong    = 1'b0;
    endtask

    task automatic modelStep();
        logic sample;
        logic prevLevel;
        if (sys_rst) begin
            modelReset();
            return;
        end
        sample     = mSync2;
        mSync2     = mSync1;
        mSync1     = bus.key_n_i;
        prevLevel  = mLevel;
        expPress   = 1'b0;
        expRelease = 1'b0;
        expLong    = 1'b0;
        if ((~sample) != mLevel) mRun++;
        else                     mRun = 0;
        if (mRun == S + 1) begin
            mLevel = ~mLevel;
            mRun   = 0;
            if (mLevel) begin
                expPress = 1'b1;
                mCount   = mCount + 8'd1;
                mHold    = 0;
                mFlagged = 1'b0;
            end else begin
                expRelease = 1'b1;
            end
        end
        if (!expPress && prevLevel && mHold < L) begin
            mHold++;
            if (mHold == L && !mFlagged) begin
                expLong  = 1'b1;
                mFlagged = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        checks++;
        assert (bus.key_level_o === mLevel) else begin
            errors++;
            $error("[TB] FAIL key_level observed=%0b expected=%0b t=%0t", bus.key_level_o, mLevel, $time);
        end
        checks++;
        assert (bus.press_o === expPress) else begin
            errors++;
            $error("[TB] FAIL press observed=%0b expected=%0b t=%0t", bus.press_o, expPress, $time);
        end
        checks++;
        assert (bus.release_o === expRelease) else begin
            errors++;
            $error("[TB] FAIL release observed=%0b expected=%0b t=%0t", bus.release_o, expRelease, $time);
        end
        checks++;
        assert (bus.long_press_o === expLong) else begin
            errors++;
            $error("[TB] FAIL long_press observed=%0b expected=%0b t=%0t", bus.long_press_o, expLong, $time);
        end
        checks++;
        assert (bus.press_count_o === mCount) else begin
            errors++;
            $error("[TB] FAIL press_count observed=%0d expected=%0d t=%0t", bus.press_count_o, mCount, $time);
        end
        checks++;
        assert (!(bus.press_o === 1'b1 && (bus.release_o === 1'b1 || bus.long_press_o === 1'b1))) else begin
            errors++;
            $error("[TB] FAIL pulse_overlap observed=p%0b r%0b l%0b expected=exclusive t=%0t",
                   bus.press_o, bus.release_o, bus.long_press_o, $time);
        end
    endtask

    task automatic checkEq(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clearSeen();
        pressSeen   = 0;
        releaseSeen = 0;
        longSeen    = 0;
    endtask

    // One clock: the model advances on the edge, outputs are compared 1 ns later.
    task automatic tick();
        @(posedge sys_clk);
        modelStep();
        #1;
        checkOutput();
        if (bus.press_o === 1'b1)      pressSeen++;
        if (bus.release_o === 1'b1)    releaseSeen++;
        if (bus.long_press_o === 1'b1) longSeen++;
    endtask

    task automatic applyStimulus(input logic k, input int n);
        for (int i = 0; i < n; i++) begin
            bus.key_n_i = k;
            tick();
        end
    endtask

    initial begin
        int pressTick;
        checks      = 0;
        errors      = 0;
        sys_rst     = 1'b1;
        bus.key_n_i = 1'b1;
        clearSeen();
        modelReset();

        #5;
        checkOutput();
        tick();
        tick();
        #4 sys_rst = 1'b0;
        applyStimulus(1'b1, 5);

        $display("[TB] clean press");
        clearSeen();
        pressTick   = 0;
        bus.key_n_i = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.press_o === 1'b1 && pressTick == 0) pressTick = i;
        end
        // Key changes just after an edge; sampled by the next edge, two sync edges then S+1 samples.
        checkEq("press_latency_ticks", pressTick, 7);
        checkEq("clean_press_pulses", pressSeen, 1);
        checkEq("clean_long_pulses", longSeen, 1);
        checkEq("clean_press_count", bus.press_count_o, 1);

        $display("[TB] release bounce");
        clearSeen();
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 10);
        checkEq("bounce_release_pulses", releaseSeen, 0);
        checkEq("bounce_long_pulses", longSeen, 0);
        checkEq("bounce_level", bus.key_level_o, 1);
        clearSeen();
        applyStimulus(1'b1, 12);
        checkEq("clean_release_pulses", releaseSeen, 1);
        checkEq("released_level", bus.key_level_o, 0);

        $display("[TB] press bounce");
        clearSeen();
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 10);
        checkEq("bounce_press_pulses", pressSeen, 0);
        checkEq("bounce_press_count", bus.press_count_o, 1);

        $display("[TB] short press");
        clearSeen();
        applyStimulus(1'b0, 8);
        applyStimulus(1'b1, 12);
        checkEq("short_press_pulses", pressSeen, 1);
        checkEq("short_release_pulses", releaseSeen, 1);
        checkEq("short_long_pulses", longSeen, 0);

        $display("[TB] counter wrap");
        #4 sys_rst = 1'b1;
        modelReset();
        tick();
        #4 sys_rst = 1'b0;
        clearSeen();
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 7);
            applyStimulus(1'b1, 7);
        end
        checkEq("wrap_press_pulses", pressSeen, 256);
        checkEq("wrap_release_pulses", releaseSeen, 256);
        checkEq("wrap_press_count", bus.press_count_o, 0);

        $display("[TB] reset mid-press");
        applyStimulus(1'b0, 10);
        checkEq("pre_reset_level", bus.key_level_o, 1);
        #7 sys_rst = 1'b1;
        modelReset();
        #1;
        checkOutput();
        clearSeen();
        tick();
        #6 sys_rst = 1'b0;
        pressTick = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.press_o === 1'b1 && pressTick == 0) pressTick = i;
        end
        checkEq("reset_repress_ticks", pressTick, 7);
        checkEq("reset_release_pulses", releaseSeen, 0);
        checkEq("reset_press_count", bus.press_count_o, 1);
        applyStimulus(1'b1, 12);

        $display("[TB] random key activity");
        for (int i = 0; i < 200; i++) begin
            logic k;
            int   n;
            k = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) n = $urandom_range(15, 30);
            else                           n = $urandom_range(1, 9);
            applyStimulus(k, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
